// File: rtl/outdigits_mixedradix_postdelims_if.sv
`default_nettype none
// ============================================================================
//  Module   : outdigits_mixedradix_postdelims_if
//  Purpose  : Valid/ready byte stream from the number formatter to the UART
//             byte transmitter.
//  Signals  : out_byte  - byte offered to the transmitter
//             out_valid - out_byte is valid
//             out_ready - transmitter accepts the byte this cycle
//  Modports : master (formatter side), slave (transmitter side)
//  Revision : 1.0 - initial release
// ============================================================================
interface outdigits_mixedradix_postdelims_if;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_byte, output out_valid, input out_ready);
  modport slave  (input out_byte, input out_valid, output out_ready);
endinterface
`default_nettype wire

// File: rtl/outdigits_mixedradix_postdelims.sv
`default_nettype none
// ============================================================================
//  Module   : outdigits_mixedradix_postdelims
//  Purpose  : Converts an unsigned NW-bit value into digit characters, either
//             in factorial base or in a fixed radix 2..16, streams them
//             most-significant first, then appends two delimiter bytes.
//  Ports    : clk          - clock, rising edge
//             reset_n      - asynchronous active-low reset
//             start        - one-cycle pulse, samples inputs, (re)starts
//             n            - value to format
//             mode         - 0 factorial base, 1 fixed radix
//             radix        - fixed radix (mode=1 only)
//             delim1byte   - first byte emitted after the digits
//             delim2byte   - second byte emitted after the digits
//             tx           - valid/ready byte stream (master side)
//             result       - 1 all digits fit, 0 overflow/invalid radix
//             result_ready - block idle and result valid
//  Revision : 1.0 - initial release
// ============================================================================
module outdigits_mixedradix_postdelims #(
  parameter int NW        = 22,
  parameter int MAXDIGITS = 12
) (
  input  wire logic                               clk,
  input  wire logic                               reset_n,
  input  wire logic                               start,
  input  wire logic [NW-1:0]                      n,
  input  wire logic                               mode,
  input  wire logic [4:0]                         radix,
  input  wire logic [7:0]                         delim1byte,
  input  wire logic [7:0]                         delim2byte,
  outdigits_mixedradix_postdelims_if.master       tx,
  output logic                                    result,
  output logic                                    result_ready
);

  localparam int          CW          = $clog2(NW + 1);
  localparam logic [CW-1:0] C_LAST_STEP = CW'(NW - 1);
  localparam logic [3:0]  C_MAXD      = 4'(MAXDIGITS);
  localparam logic [3:0]  C_MAXD_M1   = 4'(MAXDIGITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_DIV   = 3'd2,
    S_STORE = 3'd3,
    S_EMIT  = 3'd4,
    S_D1    = 3'd5,
    S_D2    = 3'd6
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic            r_mode;
  logic [4:0]      r_radix;
  logic [7:0]      r_d1;
  logic [7:0]      r_d2;
  logic [NW-1:0]   r_quo;     // dividend shifting out / quotient shifting in
  logic [3:0]      r_rem;     // partial remainder, always < r <= 16
  logic [CW-1:0]   r_cnt;     // divider step counter
  logic [4:0]      r_r;       // current radix
  logic [3:0]      r_k;       // digits stored
  logic [3:0]      r_ptr;     // buffer index of the digit being presented
  logic [3:0]      r_buf [MAXDIGITS];

  logic [4:0]      w_trial;
  logic            w_ge;
  logic [3:0]      w_diff;
  logic            w_bad_radix;
  logic            w_xfer;
  logic            w_room;
  logic [3:0]      w_ptr_m1;

  function automatic logic [7:0] f_ascii(input logic [3:0] d);
    return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
  endfunction

  // One restoring-division step: shift the next dividend bit into the
  // partial remainder and subtract the radix when it fits. Only the low
  // nibble of the difference matters since the result is below r <= 16.
  assign w_trial     = {r_rem, r_quo[NW-1]};
  assign w_ge        = (w_trial >= r_r);
  assign w_diff      = w_trial[3:0] - r_r[3:0];
  assign w_bad_radix = r_mode && ((r_radix < 5'd2) || (r_radix > 5'd16));
  assign w_xfer      = tx.out_valid && tx.out_ready;
  assign w_room      = (r_k < C_MAXD);
  assign w_ptr_m1    = r_ptr - 4'd1;
  assign result_ready = (r_state == S_IDLE) && !start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = S_IDLE;
      S_INIT:  w_next = w_bad_radix ? S_D1 : S_DIV;
      S_DIV:   if (r_cnt == C_LAST_STEP) w_next = S_STORE;
      S_STORE: w_next = (r_quo == '0) ? S_EMIT : S_DIV;
      S_EMIT:  if (w_xfer && (r_ptr == 4'd0)) w_next = S_D1;
      S_D1:    if (w_xfer) w_next = S_D2;
      S_D2:    if (w_xfer) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // A start pulse overrides whatever the block is doing.
    if (start) w_next = S_INIT;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode        <= 1'b0;
      r_radix       <= 5'd0;
      r_d1          <= 8'h00;
      r_d2          <= 8'h00;
      r_quo         <= '0;
      r_rem         <= 4'd0;
      r_cnt         <= '0;
      r_r           <= 5'd2;
      r_k           <= 4'd0;
      r_ptr         <= 4'd0;
      result        <= 1'b1;
      tx.out_valid  <= 1'b0;
      tx.out_byte   <= 8'h00;
    end else if (start) begin
      r_quo        <= n;
      r_mode       <= mode;
      r_radix      <= radix;
      r_d1         <= delim1byte;
      r_d2         <= delim2byte;
      tx.out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_r    <= r_mode ? r_radix : 5'd2;
          r_k    <= 4'd0;
          r_rem  <= 4'd0;
          r_cnt  <= '0;
          result <= !w_bad_radix;
        end
        S_DIV: begin
          r_quo <= {r_quo[NW-2:0], w_ge};
          r_rem <= w_ge ? w_diff : w_trial[3:0];
          r_cnt <= r_cnt + 1'b1;
        end
        S_STORE: begin
          // Once the buffer is full, further (more significant) digits are
          // dropped and the presented digit stays the top of the buffer.
          if (w_room) begin
            r_k   <= r_k + 4'd1;
            r_ptr <= r_k;
          end else begin
            result <= 1'b0;
            r_ptr  <= C_MAXD_M1;
          end
          if (!r_mode) r_r <= r_r + 5'd1;
          r_rem <= 4'd0;
          r_cnt <= '0;
        end
        S_EMIT: begin
          if (!tx.out_valid) begin
            tx.out_valid <= 1'b1;
            tx.out_byte  <= f_ascii(r_buf[r_ptr]);
          end else if (tx.out_ready) begin
            if (r_ptr == 4'd0) begin
              tx.out_byte <= r_d1;
            end else begin
              r_ptr       <= w_ptr_m1;
              tx.out_byte <= f_ascii(r_buf[w_ptr_m1]);
            end
          end
        end
        S_D1: begin
          // Entered with nothing presented only on the invalid-radix path.
          if (!tx.out_valid) begin
            tx.out_valid <= 1'b1;
            tx.out_byte  <= r_d1;
          end else if (tx.out_ready) begin
            tx.out_byte <= r_d2;
          end
        end
        S_D2: begin
          if (w_xfer) tx.out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Digit storage needs no reset: entries are always written before read.
  always_ff @(posedge clk) begin
    if (!start && (r_state == S_STORE) && w_room) r_buf[r_k] <= r_rem;
  end

endmodule
`default_nettype wire
